// File: rtl/shared_add_ctrl.sv
// Two-requester adder sharing one bit-serial full-add cell, round-robin arbitrated.
// Define SHARED_ADD_OVF_EN to produce signed overflow on ovf; otherwise ovf is tied low.
module shared_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, owner_q, ptr_q;
  logic             gnt0_q, gnt1_q, done_q, done_id_q, cout_q;
`ifdef SHARED_ADD_OVF_EN
  logic             cmsb_q, ovf_q;
`endif

  // Shared full-add cell built from two half-add stages; operands shift right so bit 0 is current.
  logic h1, g1, s_bit, g2, c_next;
  assign h1     = a_q[0] ^ b_q[0];
  assign g1     = a_q[0] & b_q[0];
  assign s_bit  = h1 ^ carry_q;
  assign g2     = h1 & carry_q;
  assign c_next = g1 | g2;

  // Winner: the pointer breaks ties, a lone request wins outright.
  logic any_req, win_d;
  assign any_req = req0 | req1;
  assign win_d   = (req0 & req1) ? ptr_q : req1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      sum_q     <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      owner_q   <= 1'b0;
      ptr_q     <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      cout_q    <= 1'b0;
`ifdef SHARED_ADD_OVF_EN
      cmsb_q    <= 1'b0;
      ovf_q     <= 1'b0;
`endif
    end else begin
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            a_q     <= win_d ? a1 : a0;
            b_q     <= win_d ? b1 : b0;
            owner_q <= win_d;
            ptr_q   <= ~win_d;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            gnt0_q  <= ~win_d;
            gnt1_q  <= win_d;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q   <= {s_bit, acc_q[WIDTH-1:1]};
          a_q     <= {1'b0, a_q[WIDTH-1:1]};
          b_q     <= {1'b0, b_q[WIDTH-1:1]};
          carry_q <= c_next;
          if (cnt_q == LAST_BIT) begin
`ifdef SHARED_ADD_OVF_EN
            cmsb_q  <= carry_q;
`endif
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          sum_q     <= acc_q;
          cout_q    <= carry_q;
          done_id_q <= owner_q;
          done_q    <= 1'b1;
`ifdef SHARED_ADD_OVF_EN
          ovf_q     <= cmsb_q ^ carry_q;
`endif
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign done_id = done_id_q;
  assign sum     = sum_q;
  assign cout    = cout_q;
`ifdef SHARED_ADD_OVF_EN
  assign ovf     = ovf_q;
`else
  assign ovf     = 1'b0;
`endif

endmodule

// File: tb/tb_shared_add_ctrl.sv
// Directed bench for shared_add_ctrl at WIDTH=8; ovf expectations follow SHARED_ADD_OVF_EN.
module tb_shared_add_ctrl;

`ifdef SHARED_ADD_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [7:0] a0, b0, a1, b1;
  logic       gnt0, gnt1, busy, done, done_id, cout, ovf;
  logic [7:0] sum;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  shared_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done), .done_id(done_id),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: lone request (other operands differ); 1: both requests together;
  // 2: other request raised during RUN and held.
  task automatic do_op(input string tag, input logic who, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] es, input logic ec, input logic eo, input int mode);
    logic seen_done, seen_ogt;
    @(negedge clk);
    if (who) begin a1 = a; b1 = b; end else begin a0 = a; b0 = b; end
    if (mode == 0) begin
      if (who) begin a0 = a ^ 8'hA5; b0 = b ^ 8'h3C; end
      else     begin a1 = a ^ 8'hA5; b1 = b ^ 8'h3C; end
    end else begin
      if (who) begin a0 = a; b0 = b; end else begin a1 = a; b1 = b; end
    end
    if (who) req1 = 1'b1; else req0 = 1'b1;
    if (mode == 1) begin if (who) req0 = 1'b1; else req1 = 1'b1; end
    @(negedge clk);
    chk({tag, "_gnt"}, {gnt1, gnt0, busy}, {who, ~who, 1'b1});
    if (who) req1 = 1'b0; else req0 = 1'b0;
    seen_done = 1'b0;
    seen_ogt  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0 && mode == 2) begin if (who) req0 = 1'b1; else req1 = 1'b1; end
      if (done) seen_done = 1'b1;
      if (gnt0 | gnt1) seen_ogt = 1'b1;
    end
    chk({tag, "_early"}, {seen_done, seen_ogt}, 2'b00);
    @(negedge clk);
    chk({tag, "_done"}, {done, done_id, busy, gnt0, gnt1}, {1'b1, who, 3'b000});
    chk({tag, "_res"}, {sum, cout, ovf}, {es, ec, eo});
    if (mode != 0) begin
      @(negedge clk);
      chk({tag, "_gnt2"}, {gnt1, gnt0}, {~who, who});
      if (who) req0 = 1'b0; else req1 = 1'b0;
      repeat (8) @(negedge clk);
      @(negedge clk);
      chk({tag, "_done2"}, {done, done_id}, {1'b1, ~who});
      chk({tag, "_res2"}, {sum, cout, ovf}, {es, ec, eo});
    end
  endtask

  initial begin
    logic seen;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    a0 = 8'h0; b0 = 8'h0; a1 = 8'h0; b1 = 8'h0;
    repeat (2) @(negedge clk);
    chk("reset_outs", {gnt0, gnt1, busy, done, done_id, cout, ovf, sum}, 32'h0);
    rst = 1'b0;

    do_op("add_5_3",  1'b0, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0, 0);
    do_op("add_ff_1", 1'b1, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 0);
    do_op("add_7f_1", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, OVF_ON, 0);

    // Abort an operation partway through RUN.
    @(negedge clk);
    a0 = 8'h33; b0 = 8'h44; req0 = 1'b1;
    @(negedge clk);
    req0 = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_mid_run", {busy, done}, 2'b10);
    #2 rst = 1'b1;
    #1 chk("rst_mid_run", {gnt0, gnt1, busy, done, done_id, cout, ovf, sum}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done | busy) seen = 1'b1;
    end
    chk("no_done_after_abort", seen, 1'b0);
    do_op("add_a_b", 1'b0, 8'h0A, 8'h0B, 8'h15, 1'b0, 1'b0, 0);

    // Pointer now favours req1; reset must return it to req0.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    do_op("both", 1'b0, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 1);

    do_op("held", 1'b0, 8'h21, 8'h42, 8'h63, 1'b0, 1'b0, 2);

    repeat (2) @(negedge clk);
    chk("idle_end", {busy, done, gnt0, gnt1}, 4'b0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/shared_add_ctrl.md
SHARED_ADD_CTRL -- requirements
Module: shared_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 req0  input  1  requester 0 add request.
REQ-005 a0, b0  input  WIDTH each  requester 0 operands.
REQ-006 req1  input  1  requester 1 add request.
REQ-007 a1, b1  input  WIDTH each  requester 1 operands.
REQ-008 gnt0, gnt1  output  1 each  one-cycle grant pulse, operands captured.
REQ-009 busy  output  1  high while an operation is in progress (RUN or DONE state).
REQ-010 done  output  1  one-cycle pulse, result valid.
REQ-011 done_id  output  1  requester that owns the current result (0/1).
REQ-012 sum  output  WIDTH  (a+b) mod 2^WIDTH.
REQ-013 cout  output  1  carry out of MSB.
REQ-014 ovf  output  1  signed overflow (see Configuration).

Function
REQ-015 Shall compute with a single shared 1-bit full-add cell (two half-add stages plus carry register), one bit per cycle, LSB first.
REQ-016 States: IDLE, RUN, DONE; transitions IDLE->RUN on any req sampled high, RUN->DONE after exactly WIDTH RUN cycles, DONE->IDLE unconditionally after one cycle.
REQ-017 In IDLE, at the edge where a req is sampled high: latch that requester's operands, clear the carry register and bit counter, assert the matching gnt for the following cycle only.
REQ-018 Arbitration: round-robin pointer. If both reqs are high, the pointer-favoured requester wins. After each grant, the pointer favours the other requester. After reset, the pointer favours req0.
REQ-019 If only one req is high, it is granted regardless of the pointer; the pointer still toggles to favour the other requester.
REQ-020 req sampled only in IDLE; reqs during RUN/DONE ignored, no gnt, no queuing.
REQ-021 Requester shall drop req in the cycle it sees gnt; req still high in a later IDLE cycle is a new request.
REQ-022 RUN cycle i (i=0..WIDTH-1): sum bit i = a[i]^b[i]^c; c <= majority(a[i],b[i],c).
REQ-023 Latency: done goes high WIDTH+1 cycles after the capture edge; earliest next grant is one cycle after done.
REQ-024 sum, cout, ovf, done_id update only when done is asserted and hold until the next done; intermediate bits not visible on sum.
REQ-025 gnt0 and gnt1 shall never be high together; done and gnt shall never be high in the same cycle.

Reset
REQ-026 rst high shall immediately force IDLE and drive gnt0, gnt1, busy, done, done_id, sum, cout, ovf to 0; clear the carry register and bit counter; and set the pointer to favour req0.
REQ-027 rst asserted mid-RUN or in DONE aborts the operation with no done pulse; the first request after release completes correctly.

Configuration
REQ-028 Macro SHARED_ADD_OVF_EN defined: ovf = carry into MSB XOR cout, captured at the done edge.
REQ-029 Macro SHARED_ADD_OVF_EN undefined: ovf port present, constant 0, no overflow logic.

Verification (WIDTH=8)
REQ-030 req0, a0=0x05, b0=0x03 -> gnt0 pulse, done 9 cycles after capture, sum=0x08, cout=0, done_id=0.
REQ-031 req1, a1=0xFF, b1=0x01 -> sum=0x00, cout=1, ovf=0, done_id=1.
REQ-032 After reset, req0 and req1 high together (both with 0x10+0x20) -> gnt0 first, done_id=0, then gnt1 one cycle after done, done_id=1, sum=0x30 both times.
REQ-033 a0=0x7F, b0=0x01 -> sum=0x80, cout=0; ovf=1 with SHARED_ADD_OVF_EN, ovf=0 without.
REQ-034 rst pulse in RUN cycle 4 -> all outputs 0 immediately, no done; then req0 0x0A+0x0B -> sum=0x15 after 9 cycles.
REQ-035 req1 raised during RUN of a req0 operation and held -> no gnt1 until IDLE, then gnt1 in the cycle after done.
